// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the multi-channel debouncer:
//   db_state_e : per-channel FSM state type (ZERO, WAIT1, ONE, WAIT0)
//   clog2      : counter width helper, never returns less than 1
// ---------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } db_state_e;

  // Bits needed to hold values 0 .. value-1; a width of 0 is bumped to 1 so
  // a counter for value==1 is still a legal vector.
  function automatic int clog2(input longint unsigned value);
    int w;
    w = 0;
    while ((64'd1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// ---------------------------------------------------------------------------
// debounce_multi_if
// Bundle between board pins and the debouncer.
//   btn       : raw asynchronous inputs, bit i is channel i
//   db_level  : debounced level per channel
//   rise_tick : one-cycle pulse on accepted press
//   fall_tick : one-cycle pulse on accepted release
//   hold_tick : one-cycle long-press pulse (only with DEBOUNCE_HOLD_EN)
// Modports: master drives btn and observes the outputs; slave is the debouncer.
// ---------------------------------------------------------------------------
interface debounce_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] btn;
  logic [CHANNELS-1:0] db_level;
  logic [CHANNELS-1:0] rise_tick;
  logic [CHANNELS-1:0] fall_tick;
`ifdef DEBOUNCE_HOLD_EN
  logic [CHANNELS-1:0] hold_tick;

  modport master (output btn, input db_level, input rise_tick, input fall_tick,
                  input hold_tick);
  modport slave  (input btn, output db_level, output rise_tick, output fall_tick,
                  output hold_tick);
`else
  modport master (output btn, input db_level, input rise_tick, input fall_tick);
  modport slave  (input btn, output db_level, output rise_tick, output fall_tick);
`endif
endinterface

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One debounced input: synchroniser, four-state qualify FSM with down-counter,
// registered level, press/release ticks and (with DEBOUNCE_HOLD_EN) a
// saturating long-press counter with its tick.
// Ports:
//   clk_100MHz : system clock
//   reset      : synchronous, active-high
//   btn        : raw asynchronous input
//   db_level   : debounced level (registered)
//   rise_tick  : one cycle, first cycle db_level reads 1
//   fall_tick  : one cycle, first cycle db_level reads 0
//   hold_tick  : one cycle on the HOLD_COUNT-th high cycle (DEBOUNCE_HOLD_EN)
// ---------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DB_COUNT    = 4_000_000,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_COUNT  = 100_000_000
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic btn,
  output logic db_level,
  output logic rise_tick,
`ifdef DEBOUNCE_HOLD_EN
  output logic hold_tick,
`endif
  output logic fall_tick
);

  localparam int                CNT_W    = clog2(longint'(DB_COUNT));
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DB_COUNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   high;
  logic                   db_level_q, rise_q, fall_q;

  // NOTE: every clocked block uses non-blocking assignments so all flops
  // sample the pre-edge values; blocking here would collapse the
  // synchroniser chain into a single stage.
  always_ff @(posedge clk_100MHz) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= ZERO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults first so every path assigns both outputs of this block;
  // a missing default would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ZERO: if (s) begin
        state_d = WAIT1;
        cnt_d   = CNT_LOAD;
      end
      WAIT1: begin
        if (!s)                state_d = ZERO;
        else if (cnt_q != '0)  cnt_d   = cnt_q - 1'b1;
        else                   state_d = ONE;
      end
      ONE: if (!s) begin
        state_d = WAIT0;
        cnt_d   = CNT_LOAD;
      end
      WAIT0: begin
        if (s)                 state_d = ONE;
        else if (cnt_q != '0)  cnt_d   = cnt_q - 1'b1;
        else                   state_d = ZERO;
      end
      default: state_d = ZERO;
    endcase
  end

  // The level lags the state by one register; ticks mark the cycle where the
  // registered level first shows its new value.
  assign high = (state_q == ONE) || (state_q == WAIT0);

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      db_level_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      db_level_q <= high;
      rise_q     <= high & ~db_level_q;
      fall_q     <= ~high & db_level_q;
    end
  end

  // Ticks are masked while reset is high so a tick registered just before
  // reset asserts never overlaps a reset cycle.
  assign db_level  = db_level_q;
  assign rise_tick = rise_q & ~reset;
  assign fall_tick = fall_q & ~reset;

`ifdef DEBOUNCE_HOLD_EN
  localparam int                HOLD_W   = clog2(longint'(HOLD_COUNT) + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_COUNT);

  logic [HOLD_W-1:0] hold_cnt_q;
  logic              hold_q;

  // Counter saturates at HOLD_MAX, so the compare against HOLD_MAX-1 can only
  // match once per press.
  always_ff @(posedge clk_100MHz) begin
    if (reset || !db_level_q) begin
      hold_cnt_q <= '0;
      hold_q     <= 1'b0;
    end else begin
      hold_q <= (hold_cnt_q == HOLD_MAX - 1'b1);
      if (hold_cnt_q != HOLD_MAX) hold_cnt_q <= hold_cnt_q + 1'b1;
    end
  end

  assign hold_tick = hold_q & ~reset;
`endif

endmodule

// File: rtl/debounce_multi.sv
// ---------------------------------------------------------------------------
// debounce_multi
// CHANNELS independent debouncers for buttons/switches feeding UART control.
// Optional long-press detection is built when DEBOUNCE_HOLD_EN is defined.
// Ports:
//   clk_100MHz : system clock, the only clock
//   reset      : synchronous, active-high
//   bus        : debounce_multi_if.slave (btn in; db_level, rise_tick,
//                fall_tick and optional hold_tick out)
// ---------------------------------------------------------------------------
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int DB_COUNT    = 4_000_000,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_COUNT  = 100_000_000
) (
  input logic             clk_100MHz,
  input logic             reset,
  debounce_multi_if.slave bus
);

  logic [CHANNELS-1:0] db_level;
  logic [CHANNELS-1:0] rise_tick;
  logic [CHANNELS-1:0] fall_tick;
`ifdef DEBOUNCE_HOLD_EN
  logic [CHANNELS-1:0] hold_tick;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .DB_COUNT    (DB_COUNT),
      .SYNC_STAGES (SYNC_STAGES),
      .HOLD_COUNT  (HOLD_COUNT)
    ) u_channel (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .btn        (bus.btn[i]),
      .db_level   (db_level[i]),
      .rise_tick  (rise_tick[i]),
`ifdef DEBOUNCE_HOLD_EN
      .hold_tick  (hold_tick[i]),
`endif
      .fall_tick  (fall_tick[i])
    );
  end

  assign bus.db_level  = db_level;
  assign bus.rise_tick = rise_tick;
  assign bus.fall_tick = fall_tick;
`ifdef DEBOUNCE_HOLD_EN
  assign bus.hold_tick = hold_tick;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// ---------------------------------------------------------------------------
// tb_debounce_multi
// Directed bench for debounce_multi with CHANNELS=4, DB_COUNT=4,
// SYNC_STAGES=2, HOLD_COUNT=10. Inputs change and outputs are sampled on the
// falling clock edge; "edge k" is the k-th rising edge after the inputs
// change, counting from 0. Expected press/release latency is edge 7.
// ---------------------------------------------------------------------------
module tb_debounce_multi;

  logic clk_100MHz = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  debounce_multi_if #(.CHANNELS(4)) bus ();

  debounce_multi #(
    .CHANNELS    (4),
    .DB_COUNT    (4),
    .SYNC_STAGES (2),
    .HOLD_COUNT  (10)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .bus        (bus)
  );

  task automatic step();
    @(posedge clk_100MHz);
    @(negedge clk_100MHz);
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [13:0] bounce_pat;

    // ---- reset held 3 cycles with all buttons high ----
    reset   = 1'b1;
    bus.btn = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_db",   bus.db_level,  4'h0);
      check("rst_rise", bus.rise_tick, 4'h0);
      check("rst_fall", bus.fall_tick, 4'h0);
    end
    reset = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      step();
      check("post_rst_db",   bus.db_level,  4'h0);
      check("post_rst_rise", bus.rise_tick, 4'h0);
    end
    step();  // edge 7
    check("post_rst_db_hi", bus.db_level,  4'hF);
    check("post_rst_rise",  bus.rise_tick, 4'hF);
    check("post_rst_fall",  bus.fall_tick, 4'h0);
    step();
    check("post_rst_rise_end", bus.rise_tick, 4'h0);
    check("post_rst_db_keep",  bus.db_level,  4'hF);

    // ---- release all four ----
    bus.btn = 4'h0;
    for (int i = 0; i <= 6; i++) begin
      step();
      check("relall_db",   bus.db_level,  4'hF);
      check("relall_fall", bus.fall_tick, 4'h0);
    end
    step();
    check("relall_db_lo", bus.db_level,  4'h0);
    check("relall_fall",  bus.fall_tick, 4'hF);
    check("relall_rise",  bus.rise_tick, 4'h0);
    step();
    check("relall_fall_end", bus.fall_tick, 4'h0);

    // ---- clean press / release on ch0 ----
    bus.btn = 4'b0001;
    for (int i = 0; i <= 6; i++) begin
      step();
      check("ch0_press_wait", bus.rise_tick, 4'h0);
    end
    step();
    check("ch0_press_db",   bus.db_level,  4'b0001);
    check("ch0_press_rise", bus.rise_tick, 4'b0001);
    step();
    check("ch0_press_rise_end", bus.rise_tick, 4'h0);
    check("ch0_press_db_keep",  bus.db_level,  4'b0001);
    bus.btn = 4'b0000;
    for (int i = 0; i <= 6; i++) begin
      step();
      check("ch0_rel_wait", bus.fall_tick, 4'h0);
    end
    step();
    check("ch0_rel_fall", bus.fall_tick, 4'b0001);
    check("ch0_rel_db",   bus.db_level,  4'h0);
    step();
    check("ch0_rel_fall_end", bus.fall_tick, 4'h0);

    // ---- bounce: high 3, low 1, high 3, then low ----
    bounce_pat = 14'b00000001110111;  // applied LSB first
    for (int i = 0; i < 14; i++) begin
      bus.btn = {3'b000, bounce_pat[i]};
      step();
      check("bounce_db",   bus.db_level,  4'h0);
      check("bounce_rise", bus.rise_tick, 4'h0);
      check("bounce_fall", bus.fall_tick, 4'h0);
    end
    // A 5-cycle high pulse is long enough to qualify.
    bus.btn = 4'b0001;
    for (int i = 0; i <= 4; i++) begin
      step();
      check("pulse5_wait", bus.rise_tick, 4'h0);
    end
    bus.btn = 4'b0000;
    for (int i = 5; i <= 6; i++) begin
      step();
      check("pulse5_wait", bus.rise_tick, 4'h0);
    end
    step();  // edge 7
    check("pulse5_rise", bus.rise_tick, 4'b0001);
    check("pulse5_db",   bus.db_level,  4'b0001);
    for (int i = 8; i <= 11; i++) begin
      step();
      check("pulse5_hold_db", bus.db_level,  4'b0001);
      check("pulse5_no_tick", bus.rise_tick | bus.fall_tick, 4'h0);
    end
    step();  // edge 12: release qualified
    check("pulse5_fall", bus.fall_tick, 4'b0001);
    check("pulse5_db_lo", bus.db_level, 4'h0);
    for (int i = 0; i < 4; i++) step();

    // ---- independence: ch0/ch2 pressed, ch1 toggles every cycle ----
    for (int k = 0; k <= 6; k++) begin
      bus.btn = {2'b01, (k % 2 == 1), 1'b1};
      step();
      check("indep_wait_rise", bus.rise_tick, 4'h0);
      check("indep_wait_db",   bus.db_level,  4'h0);
    end
    bus.btn = {2'b01, 1'b1, 1'b1};  // k = 7
    step();
    check("indep_rise", bus.rise_tick, 4'b0101);
    check("indep_db",   bus.db_level,  4'b0101);
    for (int k = 8; k <= 11; k++) begin
      bus.btn = {2'b01, (k % 2 == 1), 1'b1};
      step();
      check("indep_steady_db", bus.db_level, 4'b0101);
      check("indep_no_tick",   bus.rise_tick | bus.fall_tick, 4'h0);
    end
    bus.btn = 4'h0;
    for (int i = 0; i <= 6; i++) begin
      step();
      check("indep_rel_wait", bus.fall_tick, 4'h0);
    end
    step();
    check("indep_fall", bus.fall_tick, 4'b0101);
    check("indep_db_lo", bus.db_level, 4'h0);
    step();

    // ---- reset while ch0 sits in WAIT0 with cnt=2 ----
    bus.btn = 4'b0001;
    for (int i = 0; i <= 6; i++) step();
    step();
    check("mid_press_rise", bus.rise_tick, 4'b0001);
    bus.btn = 4'b0000;
    for (int i = 0; i <= 3; i++) begin  // edge 2 enters WAIT0, edge 3 cnt=2
      step();
      check("mid_wait0_db", bus.db_level, 4'b0001);
    end
    reset = 1'b1;
    check("mid_rst_cycle_fall", bus.fall_tick, 4'h0);
    step();
    check("mid_rst_db",   bus.db_level,  4'h0);
    check("mid_rst_fall", bus.fall_tick, 4'h0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("mid_after_db",   bus.db_level,  4'h0);
      check("mid_after_tick", bus.rise_tick | bus.fall_tick, 4'h0);
    end
    // Full latency again proves the FSM restarted from ZERO.
    bus.btn = 4'b0001;
    for (int i = 0; i <= 6; i++) begin
      step();
      check("mid_repress_wait", bus.db_level, 4'h0);
    end
    step();
    check("mid_repress_rise", bus.rise_tick, 4'b0001);
    bus.btn = 4'b0000;
    for (int i = 0; i <= 6; i++) step();
    step();
    check("mid_repress_fall", bus.fall_tick, 4'b0001);
    step();

`ifdef DEBOUNCE_HOLD_EN
    // ---- long press: hold_tick 10 cycles after rise_tick, once per press ----
    for (int p = 0; p < 2; p++) begin
      bus.btn = 4'b0001;
      for (int i = 0; i <= 6; i++) step();
      step();  // edge 7
      check("hold_rise", bus.rise_tick, 4'b0001);
      for (int i = 8; i <= 16; i++) begin
        step();
        check("hold_early", bus.hold_tick, 4'h0);
      end
      step();  // edge 17
      check("hold_tick", bus.hold_tick, 4'b0001);
      for (int i = 0; i < 15; i++) begin
        step();
        check("hold_once", bus.hold_tick, 4'h0);
      end
      bus.btn = 4'b0000;
      for (int i = 0; i < 12; i++) begin
        step();
        check("hold_release", bus.hold_tick, 4'h0);
      end
      check("hold_released_db", bus.db_level, 4'h0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
